// File: rtl/matrix_data_memory.sv
// Matrix operand/result memory: read-only A and B regions, writable C region,
// and a row-major valid/ready stream that dumps C.
module matrix_data_memory #(
    parameter int          DATA_W = 32,
    parameter int          DIM    = 3,
    parameter logic [31:0] A_BASE = 32'h0000_0200,
    parameter logic [31:0] B_BASE = 32'h0000_0300,
    parameter logic [31:0] C_BASE = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              err,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [2:0]        dump_row,
    output logic [2:0]        dump_col,
    output logic              dump_last,
    output logic              busy
);

    localparam int          N     = DIM * DIM;
    localparam int          IW    = $clog2(N);
    localparam logic [31:0] SPAN  = 32'(N * 4);
    localparam logic [2:0]  LASTC = 3'(DIM - 1);
    localparam logic [IW-1:0] LASTK = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state, state_nx;
    logic [IW-1:0] k, k_nx;
    logic [2:0] row, col, row_nx, col_nx;

    logic [DATA_W-1:0] c_mem [N];

    logic aligned;
    logic [31:0] off_a, off_b, off_c;
    logic hit_a, hit_b, hit_c, hit_any;
    logic [IW-1:0] idx_a, idx_b, idx_c;
    logic b_diag;
    logic [DATA_W-1:0] rd_word;

    assign aligned = (address[1:0] == 2'b00);
    assign off_a   = address - A_BASE;
    assign off_b   = address - B_BASE;
    assign off_c   = address - C_BASE;

    assign hit_a   = aligned && (address >= A_BASE) && (off_a < SPAN);
    assign hit_b   = aligned && (address >= B_BASE) && (off_b < SPAN);
    assign hit_c   = aligned && (address >= C_BASE) && (off_c < SPAN);
    assign hit_any = hit_a || hit_b || hit_c;

    assign idx_a = off_a[IW+1:2];
    assign idx_b = off_b[IW+1:2];
    assign idx_c = off_c[IW+1:2];

    // Diagonal elements sit at row-major indices that are multiples of DIM+1.
    assign b_diag = ((32'(idx_b) % 32'(DIM + 1)) == 32'd0);

    always_comb begin
        rd_word = '0;
        if (hit_c) begin
            rd_word = c_mem[idx_c];
        end else if (hit_a) begin
            rd_word = DATA_W'(idx_a) + DATA_W'(1);
        end else if (hit_b) begin
            rd_word = b_diag ? DATA_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                c_mem[i] <= '0;
            end
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            if (memread && memwrite) begin
                err <= 1'b1;
            end else if (memread) begin
                rd_valid <= 1'b1;
                data_out <= hit_any ? rd_word : '0;
                err      <= !hit_any;
            end else if (memwrite) begin
                if (hit_c && !busy) begin
                    c_mem[idx_c] <= data_in;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            row   <= row_nx;
            col   <= col_nx;
        end
    end

    assign dump_last = (state == STREAM) && (k == LASTK);
    assign dump_data = c_mem[k];
    assign dump_row  = row;
    assign dump_col  = col;

    always_comb begin
        state_nx   = state;
        k_nx       = k;
        row_nx     = row;
        col_nx     = col;
        dump_valid = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                k_nx   = '0;
                row_nx = '0;
                col_nx = '0;
                if (dump_start) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (dump_last) begin
                        state_nx = DONE;
                        k_nx     = '0;
                        row_nx   = '0;
                        col_nx   = '0;
                    end else begin
                        k_nx = k + IW'(1);
                        if (col == LASTC) begin
                            col_nx = '0;
                            row_nx = row + 3'd1;
                        end else begin
                            col_nx = col + 3'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_data_memory.sv
// Directed bench for matrix_data_memory: CPU access table plus dump,
// backpressure and mid-dump reset sequences.
module tb_matrix_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        err;
    logic        dump_start;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [2:0]  dump_row;
    logic [2:0]  dump_col;
    logic        dump_last;
    logic        busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    matrix_data_memory dut (
        .clk(clk),
        .reset(reset),
        .memread(memread),
        .memwrite(memwrite),
        .address(address),
        .data_in(data_in),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .err(err),
        .dump_start(dump_start),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data(dump_data),
        .dump_row(dump_row),
        .dump_col(dump_col),
        .dump_last(dump_last),
        .busy(busy)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        rv;
        logic        er;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive at a negedge, return at the next negedge (outputs settled).
    task automatic cpu(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
        memread  = rd;
        memwrite = wr;
        address  = a;
        data_in  = d;
        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic dump_run(input bit stall);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (stall && i == 4) begin
                dump_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk("stall_valid", dump_valid, 1);
                    chk("stall_data", dump_data, 14);
                    chk("stall_row", dump_row, 1);
                    chk("stall_col", dump_col, 1);
                    if (s == 0) begin
                        memwrite = 1'b1;
                        address  = 32'h100;
                        data_in  = 32'd99;
                    end else if (s == 1) begin
                        chk("dump_wr_err", err, 1);
                        memwrite = 1'b0;
                        memread  = 1'b1;
                        address  = 32'h200;
                    end else begin
                        chk("dump_rd_dout", data_out, 1);
                        chk("dump_rd_rv", rd_valid, 1);
                        memread = 1'b0;
                    end
                    @(negedge clk);
                end
                dump_ready = 1'b1;
            end
            chk($sformatf("beat%0d_valid", i), dump_valid, 1);
            chk($sformatf("beat%0d_data", i), dump_data, 32'(10 + i));
            chk($sformatf("beat%0d_row", i), dump_row, 32'(i / 3));
            chk($sformatf("beat%0d_col", i), dump_col, 32'(i % 3));
            chk($sformatf("beat%0d_last", i), dump_last, (i == 8) ? 1 : 0);
            @(negedge clk);
        end
        chk("done_valid", dump_valid, 0);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        vecs[0]  = '{1, 0, 32'h200, 0, 32'h1, 1, 0};
        vecs[1]  = '{1, 0, 32'h204, 0, 32'h2, 1, 0};
        vecs[2]  = '{1, 0, 32'h310, 0, 32'h1, 1, 0};
        vecs[3]  = '{1, 0, 32'h304, 0, 32'h0, 1, 0};
        vecs[4]  = '{0, 1, 32'h104, 32'h2A, 32'h0, 0, 0};
        vecs[5]  = '{1, 0, 32'h104, 0, 32'h2A, 1, 0};
        vecs[6]  = '{0, 1, 32'h200, 32'h5, 32'h2A, 0, 1};
        vecs[7]  = '{1, 0, 32'h200, 0, 32'h1, 1, 0};
        vecs[8]  = '{1, 0, 32'h124, 0, 32'h0, 1, 1};
        vecs[9]  = '{1, 0, 32'h208, 0, 32'h3, 1, 0};
        vecs[10] = '{1, 0, 32'h102, 0, 32'h0, 1, 1};
        vecs[11] = '{1, 0, 32'h220, 0, 32'h9, 1, 0};
        vecs[12] = '{1, 0, 32'h224, 0, 32'h0, 1, 1};
        vecs[13] = '{1, 0, 32'h200, 0, 32'h1, 1, 0};
        vecs[14] = '{1, 1, 32'h104, 32'h7, 32'h1, 0, 1};
        vecs[15] = '{0, 0, 32'h0, 0, 32'h1, 0, 0};
        vecs[16] = '{1, 0, 32'h0FC, 0, 32'h0, 1, 1};

        reset      = 1'b1;
        memread    = 1'b1;
        memwrite   = 1'b1;
        address    = 32'h104;
        data_in    = 32'hDEAD;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        chk("rst_dout", data_out, 0);
        chk("rst_rv", rd_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", dump_valid, 0);

        for (int i = 0; i < 17; i++) begin
            cpu(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
            chk($sformatf("v%0d_dout", i), data_out, vecs[i].dout);
            chk($sformatf("v%0d_rv", i), rd_valid, vecs[i].rv);
            chk($sformatf("v%0d_err", i), err, vecs[i].er);
        end

        for (int i = 0; i < 9; i++) begin
            cpu(0, 1, 32'h100 + 32'(4 * i), 32'(10 + i));
            chk($sformatf("load%0d_err", i), err, 0);
        end
        cpu(1, 0, 32'h120, 0);
        chk("c8_read", data_out, 18);

        dump_run(0);
        dump_run(1);
        cpu(1, 0, 32'h100, 0);
        chk("c0_unchanged", data_out, 10);

        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pre%0d_data", i), dump_data, 32'(10 + i));
            @(negedge clk);
        end
        chk("pre_rst_busy", busy, 1);
        do_reset();
        chk("mrst_valid", dump_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_last", dump_last, 0);
        chk("mrst_row", dump_row, 0);
        chk("mrst_col", dump_col, 0);
        chk("mrst_dout", data_out, 0);
        dump_ready = 1'b0;
        @(negedge clk);
        chk("mrst_idle", busy, 0);
        cpu(1, 0, 32'h204, 0);
        chk("mrst_a1", data_out, 2);
        cpu(1, 0, 32'h110, 0);
        chk("mrst_c4", data_out, 0);
        cpu(1, 0, 32'h320, 0);
        chk("mrst_b8", data_out, 1);
        cpu(1, 0, 32'h31C, 0);
        chk("mrst_b7", data_out, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/matrix_data_memory.md
MATRIX_DATA_MEMORY -- requirements
Module: matrix_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits.
REQ-002 SHALL have parameter DIM, default 3 (legal range 2..8), meaning square matrix dimension; each region holds DIM*DIM words.
REQ-003 SHALL have parameter A_BASE, default 32'h0000_0200, meaning byte base address of read-only operand region A.
REQ-004 SHALL have parameter B_BASE, default 32'h0000_0300, meaning byte base address of read-only operand region B.
REQ-005 SHALL have parameter C_BASE, default 32'h0000_0100, meaning byte base address of writable result region C.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 memread  input  1  read request for the current cycle.
REQ-009 memwrite  input  1  write request for the current cycle.
REQ-010 address  input  32  byte address, word aligned.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 data_out  output  DATA_W  registered read data.
REQ-013 rd_valid  output  1  data_out valid, one-cycle pulse.
REQ-014 err  output  1  registered access-error pulse.
REQ-015 dump_start  input  1  pulse that starts streaming region C.
REQ-016 dump_valid / dump_ready  output / input  1 / 1  stream handshake.
REQ-017 dump_data  output  DATA_W  current C element.
REQ-018 dump_row, dump_col  output  3 each  row/column index of dump_data.
REQ-019 dump_last  output  1  high with the final element (row DIM-1, col DIM-1).
REQ-020 busy  output  1  high while the dump FSM is not IDLE.

Function
REQ-021 Word index = (address - base) >> 2; an access hits a region when address[1:0]==0 and 0 <= index < DIM*DIM.
REQ-022 Read (memread=1, memwrite=0) hitting A, B or C SHALL load data_out with the word and pulse rd_valid the following cycle (latency 1).
REQ-023 Read missing every region or misaligned SHALL load data_out=0, pulse rd_valid and pulse err next cycle.
REQ-024 Write (memwrite=1, memread=0) hitting C while busy=0 SHALL update C[index] at that edge; a read of the same word on the next cycle returns the new value.
REQ-025 Write to A, B, unmapped or misaligned address, or to C while busy=1, SHALL be discarded and pulse err next cycle; data_out unchanged.
REQ-026 memread=1 and memwrite=1 together SHALL perform no access and pulse err next cycle; rd_valid stays 0.
REQ-027 With no request, data_out SHALL hold its value and rd_valid, err SHALL be 0.
REQ-028 Dump FSM states IDLE, STREAM, DONE; IDLE->STREAM on dump_start with index counter=0; dump_start in STREAM or DONE ignored.
REQ-029 In STREAM dump_valid=1 and dump_data=C[k], row=k/DIM, col=k%DIM (row-major); k advances only when dump_valid and dump_ready both high.
REQ-030 Handshake on k=DIM*DIM-1 (dump_last=1) SHALL move to DONE; DONE lasts one cycle (dump_valid=0, busy=1) then IDLE.
REQ-031 dump_data, row, col SHALL stay stable while dump_valid=1 and dump_ready=0.
REQ-032 CPU reads SHALL be served normally during STREAM, independent of the dump port.

Reset
REQ-033 reset at any edge, including mid-dump, SHALL force FSM IDLE, counter 0, data_out=0, rd_valid=0, err=0, dump_valid=0, dump_last=0, busy=0, row=col=0.
REQ-034 reset SHALL load A[i]=i+1, B=identity (1 on diagonal, 0 elsewhere), C all 0; any request in the reset cycle is ignored.

Verification
REQ-035 After reset, read 32'h200, 32'h204, 32'h310 -> data_out 1, 2, 1, each with rd_valid one cycle later, err=0.
REQ-036 Write 32'h2A at 32'h104 then read 32'h104 -> data_out 32'h2A; write 5 at 32'h200 -> err pulse, later read of 32'h200 still 1.
REQ-037 Read 32'h124 (index 9, DIM=3), read 32'h102, memread=memwrite=1 -> err each time, data_out 0 for the two reads, no rd_valid for the third.
REQ-038 C loaded 10..18, dump_start, dump_ready=1 -> 9 consecutive beats 10..18, row/col (0,0)..(2,2), dump_last on 18, busy low two cycles after last beat.
REQ-039 Same dump with dump_ready low 3 cycles on beat (1,1) -> value 14 held stable, then stream resumes; write to C during dump -> err, C unchanged.
REQ-040 reset asserted after beat 4 -> dump_valid=0, busy=0 next cycle; C reads return 0, A/B restored.
